// File: rtl/ttt_pkg.sv
// ttt_pkg -- shared definitions for the tic-tac-toe game controller.
//   cell_t     : 2-bit cell codes stored in the packed board
//   state_t    : controller state enumeration
//   NUM_CELLS  : number of board cells (3x3)
//   CELL_IDX_W : width of a cell index on the move ports
//   get_cell / set_cell : safe indexed access into the packed board
package ttt_pkg;

  localparam int NUM_CELLS  = 9;
  localparam int CELL_IDX_W = 4;
  localparam int BOARD_W    = 2 * NUM_CELLS;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    PLAYER = 2'b01,
    BOT    = 2'b10
  } cell_t;

  typedef enum logic [2:0] {
    IDLE,
    P_TURN,
    P_CHECK,
    B_TURN,
    B_CHECK,
    DONE
  } state_t;

  // Read one cell. Indices past the last cell read as 11 so they never
  // look empty and a move to them is rejected with no extra compare.
  function automatic logic [1:0] get_cell(input logic [BOARD_W-1:0]    b,
                                          input logic [CELL_IDX_W-1:0] idx);
    logic [1:0] r;
    r = 2'b11;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == CELL_IDX_W'(i)) r = b[2*i +: 2];
    end
    return r;
  endfunction

  // Write one cell; out-of-range indices leave the board untouched.
  function automatic logic [BOARD_W-1:0] set_cell(input logic [BOARD_W-1:0]    b,
                                                  input logic [CELL_IDX_W-1:0] idx,
                                                  input cell_t                 code);
    logic [BOARD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == CELL_IDX_W'(i)) r[2*i +: 2] = code;
    end
    return r;
  endfunction

endpackage

// File: rtl/win_checker.sv
// win_checker -- combinational three-in-a-row detector.
// Ports:
//   board_i  [17:0] packed board, cell n at [2n+1:2n]
//   winner_o [1:0]  PLAYER / BOT when that side owns a full line, else EMPTY
module win_checker
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] board_i,
  output logic [1:0]         winner_o
);

  function automatic logic owns(input logic [BOARD_W-1:0] b,
                                input int a, input int m, input int z,
                                input cell_t code);
    return (b[2*a +: 2] == code) && (b[2*m +: 2] == code) && (b[2*z +: 2] == code);
  endfunction

  // Any of the eight lines: three rows, three columns, two diagonals.
  function automatic logic any_line(input logic [BOARD_W-1:0] b, input cell_t code);
    return owns(b, 0, 1, 2, code) | owns(b, 3, 4, 5, code) | owns(b, 6, 7, 8, code) |
           owns(b, 0, 3, 6, code) | owns(b, 1, 4, 7, code) | owns(b, 2, 5, 8, code) |
           owns(b, 0, 4, 8, code) | owns(b, 2, 4, 6, code);
  endfunction

  always_comb begin
    // Both sides cannot own a line in legal play; player wins the tie.
    if (any_line(board_i, PLAYER))   winner_o = PLAYER;
    else if (any_line(board_i, BOT)) winner_o = BOT;
    else                             winner_o = EMPTY;
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl -- tic-tac-toe game controller between a player port and a
// bot engine. Validates moves, keeps the registered board, and reports the
// game result after each move is checked.
// Parameters:
//   BOT_FIRST   1 = bot moves first after start
//   TIMEOUT_CYC player move timeout in clk cycles (only with the macro below)
// Optional feature: define TTT_MOVE_TIMEOUT_EN to forfeit a player turn that
// sees no accepted move within TIMEOUT_CYC cycles.
// Ports:
//   clk, rst (sync, active-high), start
//   move_valid, move_cell[3:0]      player move strobe / target
//   bot_req (out), bot_ack, bot_cell[3:0]  bot handshake
//   board[17:0], player_turn, move_err, winner[1:0], draw, game_over
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned BOT_FIRST   = 0,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  move_valid,
  input  logic [CELL_IDX_W-1:0] move_cell,
  output logic                  bot_req,
  input  logic                  bot_ack,
  input  logic [CELL_IDX_W-1:0] bot_cell,
  output logic [BOARD_W-1:0]    board,
  output logic                  player_turn,
  output logic                  move_err,
  output logic [1:0]            winner,
  output logic                  draw,
  output logic                  game_over
);

  localparam logic [3:0] FULL_CNT = 4'(NUM_CELLS);

  state_t               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [1:0]           winner_q, winner_d;
  logic                 draw_q, draw_d;
  logic                 move_err_q, move_err_d;

  logic [1:0]           chk_winner;
  logic [3:0]           cnt_inc;
  logic                 player_ok;
  logic                 bot_ok;

`ifdef TTT_MOVE_TIMEOUT_EN
  localparam int            TO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_expired;

  assign to_expired = (to_cnt_q == TO_LAST);
`endif

  win_checker u_win_checker (
    .board_i  (board_q),
    .winner_o (chk_winner)
  );

  // Move count saturates at a full board so it can never wrap.
  assign cnt_inc   = (cnt_q >= FULL_CNT) ? FULL_CNT : cnt_q + 4'd1;
  assign player_ok = move_valid && (get_cell(board_q, move_cell) == EMPTY);
  assign bot_ok    = bot_ack    && (get_cell(board_q, bot_cell)  == EMPTY);

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    cnt_d      = cnt_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    move_err_d = 1'b0;
`ifdef TTT_MOVE_TIMEOUT_EN
    // Cleared in every other state, so P_TURN is always entered at 0.
    to_cnt_d   = '0;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          board_d  = '0;
          cnt_d    = '0;
          winner_d = EMPTY;
          draw_d   = 1'b0;
          state_d  = (BOT_FIRST != 0) ? B_TURN : P_TURN;
        end
      end

      P_TURN: begin
        if (player_ok) begin
          board_d = set_cell(board_q, move_cell, PLAYER);
          cnt_d   = cnt_inc;
          state_d = P_CHECK;
        end else begin
          if (move_valid) move_err_d = 1'b1;
`ifdef TTT_MOVE_TIMEOUT_EN
          // A legal move on the expiry cycle took the branch above instead.
          if (to_expired) begin
            move_err_d = 1'b1;
            state_d    = B_TURN;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
`endif
        end
      end

      B_TURN: begin
        if (bot_ok) begin
          board_d = set_cell(board_q, bot_cell, BOT);
          cnt_d   = cnt_inc;
          state_d = B_CHECK;
        end else if (bot_ack) begin
          move_err_d = 1'b1;
        end
      end

      P_CHECK, B_CHECK: begin
        // A win beats a full board, so a ninth-move win never flags draw.
        if (chk_winner != EMPTY) begin
          winner_d = chk_winner;
          state_d  = DONE;
        end else if (cnt_q == FULL_CNT) begin
          draw_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = (state_q == P_CHECK) ? B_TURN : P_TURN;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      board_q    <= '0;
      cnt_q      <= '0;
      winner_q   <= EMPTY;
      draw_q     <= 1'b0;
      move_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      cnt_q      <= cnt_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      move_err_q <= move_err_d;
    end
  end

`ifdef TTT_MOVE_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`endif

  assign board       = board_q;
  assign winner      = winner_q;
  assign draw        = draw_q;
  assign move_err    = move_err_q;
  assign player_turn = (state_q == P_TURN);
  assign bot_req     = (state_q == B_TURN);
  assign game_over   = (state_q == DONE);

endmodule
